// File: rtl/alu_pkg.sv
// alu_pkg: ARM data-processing opcodes, NZCV flag bit indices and the
// multiply FSM state type used by alu_seq.
package alu_pkg;
  localparam logic [3:0] AND = 4'h0, EOR = 4'h1, SUB = 4'h2, RSB = 4'h3,
                         ADD = 4'h4, ADC = 4'h5, SBC = 4'h6, RSC = 4'h7,
                         TST = 4'h8, TEQ = 4'h9, CMP = 4'hA, CMN = 4'hB,
                         ORR = 4'hC, MOV = 4'hD, BIC = 4'hE, MVN = 4'hF;
  localparam int NEG = 3, ZER = 2, CAR = 1, OVR = 0;
  typedef enum logic {IDLE, MUL} state_e;
endpackage

// File: rtl/alu_seq_mul_iter.sv
// mul_iter: shift-add multiplier producing the low WIDTH bits of a*b+acc,
// retiring MUL_BITS multiplier bits per cycle; done_o marks the final step.
module mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);
  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CW = $clog2(STEPS + 1);
  logic [WIDTH-1:0] mcand_q, mplier_q, sum_q, sum_d;
  logic [CW-1:0] cnt_q;
  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < MUL_BITS; i++) sum_d = sum_d + (mplier_q[i] ? (mcand_q << i) : '0);
  end
  // The last step's sum goes straight out so the caller loads it on the same edge.
  assign done_o = cnt_q == CW'(1);
  assign prod_o = sum_d;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      sum_q    <= acc_i;
      cnt_q    <= CW'(STEPS);
    end else if (cnt_q != '0) begin
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      sum_q    <= sum_d;
      cnt_q    <= cnt_q - CW'(1);
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ARM data-processing ALU with a registered result and NZCV
// register; define ALU_MUL_EN to add the iterative MUL/MLA path.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             set_flags,
  input  logic             is_mul,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             shift_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_we,
  output logic [3:0]       flags,
  output logic             busy
);
  logic [WIDTH-1:0] result_q, result_d, alu_res, x, y, mul_prod;
  logic [WIDTH:0] sum;
  logic [3:0] flags_q, flags_d;
  logic out_valid_q, out_valid_d, res_we_q, res_we_d;
  logic accept, arith, test, cin, ovf, mul_cmd, mul_done, mul_flag_we;
  assign in_ready = !reset && !busy && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign arith = opcode inside {SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN};
  assign test = opcode[3:2] == 2'b10;
  assign x = (opcode inside {RSB, RSC}) ? ~a : a;
  assign y = (opcode inside {SUB, SBC, CMP}) ? ~b : b;
  assign cin = (opcode inside {SUB, RSB, CMP}) || ((opcode inside {ADC, SBC, RSC}) && flags_q[CAR]);
  assign sum = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
  assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  always_comb
    case (opcode)
      AND, TST: alu_res = a & b;
      EOR, TEQ: alu_res = a ^ b;
      ORR:      alu_res = a | b;
      MOV:      alu_res = b;
      BIC:      alu_res = a & ~b;
      MVN:      alu_res = ~b;
      default:  alu_res = sum[WIDTH-1:0];
    endcase
  // Single-cycle accepts and multiply completion are exclusive: busy blocks accepts.
  always_comb begin
    result_d    = result_q;
    res_we_d    = res_we_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept && !mul_cmd) begin
      out_valid_d = 1'b1;
      result_d    = is_mul ? '0 : alu_res;
      res_we_d    = !is_mul && !test;
      if (!is_mul && (set_flags || test))
        flags_d = {alu_res[WIDTH-1], alu_res == '0, arith ? sum[WIDTH] : shift_c, arith ? ovf : flags_q[OVR]};
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_prod;
      res_we_d    = 1'b1;
      if (mul_flag_we) flags_d[NEG:ZER] = {mul_prod[WIDTH-1], mul_prod == '0};
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      result_q    <= '0;
      res_we_q    <= 1'b0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      result_q    <= result_d;
      res_we_q    <= res_we_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  assign result = result_q;
  assign res_we = res_we_q;
  assign out_valid = out_valid_q;
  assign flags = flags_q;
`ifdef ALU_MUL_EN
  state_e state_q, state_d;
  logic mul_sf_q;
  assign mul_cmd = is_mul;
  assign busy = state_q == MUL;
  assign mul_flag_we = mul_sf_q;
  always_comb state_d = (accept && is_mul) ? MUL : mul_done ? IDLE : state_q;
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= IDLE;
      mul_sf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && is_mul) mul_sf_q <= set_flags;
    end
  mul_iter #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) u_mul (
    .clk     (clk),
    .rst     (reset),
    .start_i (accept && is_mul),
    .a_i     (a),
    .b_i     (b),
    .acc_i   (accumulate ? acc : '0),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`else
  logic unused_mul;
  assign mul_cmd = 1'b0;
  assign busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign mul_flag_we = 1'b0;
  assign unused_mul = ^{acc, accumulate, MUL_BITS != 0};
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an integer-arithmetic
// model; multiply scenarios follow whether ALU_MUL_EN is defined.
module tb_alu_seq;
  import alu_pkg::*;
  localparam int W = 32;
  localparam int MB = 1;
  logic clk = 0, reset = 1, in_valid = 0, set_flags = 0, is_mul = 0, accumulate = 0;
  logic shift_c = 0, out_ready = 1;
  logic in_ready, out_valid, res_we, busy;
  logic [3:0] opcode = 0, flags;
  logic [W-1:0] a = 0, b = 0, acc = 0, result;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_BITS(MB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .set_flags(set_flags), .is_mul(is_mul), .accumulate(accumulate),
    .a(a), .b(b), .acc(acc), .shift_c(shift_c), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .res_we(res_we), .flags(flags), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: pick = '0;
      1: pick = 1;
      2: pick = 32'h7FFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'hFFFF_FFFF;
      default: pick = $urandom;
    endcase
  endfunction

  // Reference: ARM semantics via 64-bit integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a_, b_,
                                input logic sf, sh, input logic [3:0] fi,
                                output logic [3:0] fo, output logic [W-1:0] r, output logic we);
    longint ua, ub, sa, sb, u, s, ci;
    logic cv, vv, ar, tst;
    ua = longint'(a_); ub = longint'(b_);
    sa = longint'($signed(a_)); sb = longint'($signed(b_));
    ci = fi[1] ? 1 : 0;
    ar = 1; s = 0; u = 0; cv = sh;
    case (op)
      SUB, CMP: begin u = ua - ub; s = sa - sb; cv = u >= 0; end
      RSB:      begin u = ub - ua; s = sb - sa; cv = u >= 0; end
      ADD, CMN: begin u = ua + ub; s = sa + sb; cv = u >= 64'h1_0000_0000; end
      ADC:      begin u = ua + ub + ci; s = sa + sb + ci; cv = u >= 64'h1_0000_0000; end
      SBC:      begin u = ua - ub - (1 - ci); s = sa - sb - (1 - ci); cv = u >= 0; end
      RSC:      begin u = ub - ua - (1 - ci); s = sb - sa - (1 - ci); cv = u >= 0; end
      AND, TST: begin u = ua & ub; ar = 0; end
      EOR, TEQ: begin u = ua ^ ub; ar = 0; end
      ORR:      begin u = ua | ub; ar = 0; end
      MOV:      begin u = ub; ar = 0; end
      BIC:      begin u = ua & ~ub; ar = 0; end
      default:  begin u = longint'(~b_); ar = 0; end
    endcase
    r = u[W-1:0];
    vv = ar ? (s != longint'($signed(s[31:0]))) : fi[0];
    tst = op inside {TST, TEQ, CMP, CMN};
    fo = (sf || tst) ? {r[W-1], r == 0, cv, vv} : fi;
    we = !tst;
  endfunction

  task automatic op1(input logic [3:0] op, input logic [W-1:0] aa, bb, input logic sf, sh);
    @(negedge clk);
    in_valid = 1; is_mul = 0; opcode = op; a = aa; b = bb; set_flags = sf; shift_c = sh;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic test_reset;
    in_valid = 1; opcode = ADD; a = 5; b = 6; set_flags = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if (res_we !== 1'b0) begin n_err++; $display("FAIL reset_res_we: got %b want 0", res_we); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 0; in_valid = 0;
  endtask

  task automatic test_directed;
    op1(ADD, 32'h7FFF_FFFF, 1, 1, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL adds_latency: out_valid %b want 1", out_valid); end
    n_cmp++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL adds_result: got %h want 80000000", result); end
    n_cmp++; if (flags !== 4'b1001) begin n_err++; $display("FAIL adds_flags: got %b want 1001", flags); end
    n_cmp++; if (res_we !== 1'b1) begin n_err++; $display("FAIL adds_res_we: got %b want 1", res_we); end
    op1(SUB, 5, 5, 1, 0);
    n_cmp++; if (result !== 0 || flags !== 4'b0110) begin n_err++; $display("FAIL subs: got %h/%b want 0/0110", result, flags); end
    op1(ADC, 1, 1, 0, 0);
    n_cmp++; if (result !== 3 || flags !== 4'b0110) begin n_err++; $display("FAIL adc_carry: got %h/%b want 3/0110", result, flags); end
    op1(CMP, 3, 7, 0, 0);
    n_cmp++; if (res_we !== 1'b0 || flags !== 4'b1000) begin n_err++; $display("FAIL cmp: we/flags %b/%b want 0/1000", res_we, flags); end
    op1(TST, 32'hF0, 32'h0F, 0, 1);
    n_cmp++; if (res_we !== 1'b0 || flags !== 4'b0110) begin n_err++; $display("FAIL tst: we/flags %b/%b want 0/0110", res_we, flags); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 0;
    in_valid = 1; is_mul = 0; opcode = ADD; a = 1; b = 2; set_flags = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    opcode = SUB; a = 10; b = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (result !== 3 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold cycle %0d: got %h/%b want 3/1", i, result, out_valid); end
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (result !== 7 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second: got %h/%b want 7/1", result, out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: out_valid %b want 0", out_valid); end
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input logic [W-1:0] aa, bb, ac, input logic accum, sf, output int lat);
    @(negedge clk);
    in_valid = 1; is_mul = 1; accumulate = accum; a = aa; b = bb; acc = ac; set_flags = sf;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_accept: in_ready %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0; is_mul = 0;
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mul_busy: busy/in_ready %b/%b want 1/0", busy, in_ready); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic test_mul;
    int lat;
    logic [63:0] p;
    logic [W-1:0] ra, rb, rc;
    logic racc;
    op1(ADD, 32'h8000_0000, 32'h8000_0000, 1, 0);
    n_cmp++; if (flags !== 4'b0111) begin n_err++; $display("FAIL mul_preflags: got %b want 0111", flags); end
    run_mul(32'h0000_FFFF, 32'h0001_0001, 0, 0, 1, lat);
    n_cmp++; if (lat !== W / MB) begin n_err++; $display("FAIL muls_latency: got %0d want %0d", lat, W / MB); end
    n_cmp++; if (result !== 32'hFFFF_FFFF || res_we !== 1'b1) begin n_err++; $display("FAIL muls_result: got %h/%b want ffffffff/1", result, res_we); end
    n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL muls_flags: got %b want 1011", flags); end
    run_mul(32'h0000_FFFF, 32'h0001_0001, 1, 1, 1, lat);
    n_cmp++; if (result !== 0 || flags !== 4'b0111) begin n_err++; $display("FAIL mla: got %h/%b want 0/0111", result, flags); end
    for (int i = 0; i < 3; i++) begin
      ra = pick(); rb = $urandom; rc = $urandom; racc = 1'($urandom_range(0, 1));
      p = {32'b0, ra} * {32'b0, rb} + (racc ? {32'b0, rc} : 64'b0);
      run_mul(ra, rb, rc, racc, 0, lat);
      n_cmp++; if (result !== p[W-1:0] || flags !== 4'b0111 || lat !== W / MB)
        begin n_err++; $display("FAIL mul_rand %0d: got %h/%b/%0d want %h/0111/%0d", i, result, flags, lat, p[W-1:0], W / MB); end
    end
  endtask

  task automatic test_mul_reset;
    int stray;
    @(negedge clk);
    in_valid = 1; is_mul = 1; accumulate = 0; a = $urandom; b = $urandom; set_flags = 1;
    @(negedge clk);
    in_valid = 0; is_mul = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mulrst_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    reset = 0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || flags !== 4'b0000)
      begin n_err++; $display("FAIL mulrst_state: valid/busy/flags %b/%b/%b want 0/0/0000", out_valid, busy, flags); end
    in_valid = 1; opcode = ADD; a = 2; b = 2; set_flags = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mulrst_accept: in_ready %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (result !== 4 || out_valid !== 1'b1 || flags !== 4'b0000)
      begin n_err++; $display("FAIL mulrst_next: got %h/%b/%b want 4/1/0000", result, out_valid, flags); end
    stray = 0;
    repeat (40) begin @(negedge clk); if (out_valid === 1'b1) stray++; end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL mulrst_stray: %0d valid cycles want 0", stray); end
  endtask
`else
  task automatic test_mul_disabled;
    op1(CMP, 3, 7, 0, 0);
    @(negedge clk);
    in_valid = 1; is_mul = 1; a = 5; b = 6; set_flags = 1;
    @(negedge clk);
    in_valid = 0; is_mul = 0;
    n_cmp++; if (out_valid !== 1'b1 || result !== 0 || res_we !== 1'b0)
      begin n_err++; $display("FAIL muloff_out: valid/result/we %b/%h/%b want 1/0/0", out_valid, result, res_we); end
    n_cmp++; if (flags !== 4'b1000 || busy !== 1'b0) begin n_err++; $display("FAIL muloff_flags: flags/busy %b/%b want 1000/0", flags, busy); end
  endtask
`endif

  task automatic test_back_to_back;
    logic [3:0] mf, op;
    logic [W-1:0] ra, rb, er;
    logic ewe, sf, sh;
    @(negedge clk);
    reset = 1; in_valid = 0;
    @(negedge clk);
    reset = 0; out_ready = 1; mf = 4'b0000;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15)); ra = pick(); rb = pick();
      sf = 1'($urandom_range(0, 1)); sh = 1'($urandom_range(0, 1));
      in_valid = 1; is_mul = 0; opcode = op; a = ra; b = rb; set_flags = sf; shift_c = sh;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready %0d: got %b want 1", i, in_ready); end
      model(op, ra, rb, sf, sh, mf, mf, er, ewe);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || result !== er || res_we !== ewe)
        begin n_err++; $display("FAIL b2b_result %0d op %h: got %b/%h/%b want 1/%h/%b", i, op, out_valid, result, res_we, er, ewe); end
      n_cmp++; if (flags !== mf) begin n_err++; $display("FAIL b2b_flags %0d op %h: got %b want %b", i, op, flags, mf); end
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
`ifdef ALU_MUL_EN
    test_mul;
    test_mul_reset;
`else
    test_mul_disabled;
`endif
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
